// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the CPU/DMA memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [0:0] {S_CPU, S_DMA} arb_state_t;

  localparam int unsigned MAX_BURST_DEF = 8;
  localparam int unsigned CPU_SLOT_DEF  = 2;
  localparam int unsigned ARB_CNT_W     = 8;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Cycle-by-cycle arbiter between the 65C02 and one DMA requester on the shared bus.
// DMA bursts are bounded, and the CPU read byte is held while RDY is low.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  parameter int unsigned CPU_SLOT  = CPU_SLOT_DEF
) (
  input  logic        clk,
  input  logic        resb,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        rdy,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic        dma_we,
  input  logic [7:0]  dma_wdata,
  output logic        dma_gnt,
  output logic [7:0]  dma_rdata,
  output logic        dma_rvalid,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [ARB_CNT_W-1:0] BurstLast = ARB_CNT_W'(MAX_BURST - 1);
  localparam logic [ARB_CNT_W-1:0] SlotLoad  = ARB_CNT_W'(CPU_SLOT - 1);

  arb_state_t           state_q, state_d;
  logic [ARB_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [ARB_CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic                 prev_cpu_q;
  logic [7:0]           hold_q;
  logic                 rvalid_q;

  always_ff @(posedge clk) begin
    if (!resb) begin
      state_q     <= S_CPU;
      burst_cnt_q <= '0;
      slot_cnt_q  <= '0;
      prev_cpu_q  <= 1'b0;
      hold_q      <= 8'h00;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      slot_cnt_q  <= slot_cnt_d;
      prev_cpu_q  <= rdy;
      rvalid_q    <= dma_gnt && !dma_we;
      // Capture only the byte from a real CPU cycle so it survives the stall.
      if (prev_cpu_q) hold_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    slot_cnt_d  = slot_cnt_q;
    unique case (state_q)
      S_CPU: begin
        if (slot_cnt_q != '0) begin
          slot_cnt_d = slot_cnt_q - 1'b1;
        end else if (dma_req) begin
          state_d     = S_DMA;
          burst_cnt_d = '0;
        end
      end
      S_DMA: begin
        if (dma_gnt && (burst_cnt_q == BurstLast)) begin
          state_d     = S_CPU;
          slot_cnt_d  = SlotLoad;
          burst_cnt_d = '0;
        end else if (dma_gnt) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end else begin
          state_d     = S_CPU;
          slot_cnt_d  = '0;
          burst_cnt_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    rdy       = (state_q == S_CPU);
    dma_gnt   = (state_q == S_DMA) && dma_req;
    mem_addr  = cpu_addr;
    mem_we    = cpu_we;
    mem_wdata = cpu_wdata;
    if (dma_gnt) begin
      mem_addr  = dma_addr;
      mem_we    = dma_we;
      mem_wdata = dma_wdata;
    end else if (state_q == S_DMA) begin
      mem_we = 1'b0;
    end
    cpu_rdata  = prev_cpu_q ? mem_rdata : hold_q;
    dma_rdata  = mem_rdata;
    dma_rvalid = rvalid_q;
  end

endmodule
